id_ex_hazard_reg: RTL
=====================

// Module: id_ex_hazard_reg
// PURPOSE
// - ID/EX pipeline register with load-use hazard detection, bubble insertion and a
//   WB->ID register-file bypass.
// - Captures decoded operands and controls from ID and presents them to the EX stage.
// - EX_RegAddr1/EX_RegAddr2 drive the forwarding unit's RegAddr1/RegAddr2 inputs.
// - Stall_out freezes PC and IF/ID.
// PARAMETERS
// - XLEN     32  datapath width
// - ALUOP_W  4   width of ALU operation code
// - CNT_W    16  width of the saturating bubble counter
// PORTS
// - clk           in   1        single clock, rising edge
// - rst_n         in   1        asynchronous, active-low reset
// - ID_Valid      in   1        ID holds a real instruction
// - ID_PC         in   XLEN     PC of the ID instruction
// - ID_Rs1Data    in   XLEN     register-file read port 1
// - ID_Rs2Data    in   XLEN     register-file read port 2
// - ID_Imm        in   XLEN     decoded immediate
// - ID_RegAddr1   in   5        rs1 address
// - ID_RegAddr2   in   5        rs2 address
// - ID_RdAddr     in   5        rd address
// - ID_UseRs1     in   1        instruction reads rs1
// - ID_UseRs2     in   1        instruction reads rs2
// - ID_ALUOp      in   ALUOP_W  ALU operation
// - ID_ALUSrc     in   1        operand B select: 1 = imm, 0 = rs2
// - ID_MemRead    in   1        load
// - ID_MemWrite   in   1        store
// - ID_RegWrite   in   1        writes rd
// - ID_MemToReg   in   1        WB selects memory data
// - ID_Branch     in   1        branch/jump
// - WB_RegWrite   in   1        WB stage writes the register file
// - WB_RdAddr     in   5        WB destination
// - WB_Data       in   XLEN     WB result
// - Stall_in      in   1        downstream (data memory) stall: hold everything
// - Flush         in   1        branch taken in EX: kill the ID instruction
// - EX_*          out  (same widths as the ID_* fields above) registered copies;
//                 EX_Valid 1, EX_RegAddr1/EX_RegAddr2/EX_RdAddr 5, data XLEN
// - Stall_out     out  1        freeze PC and IF/ID this cycle
// - LoadUse       out  1        load-use hazard detected this cycle
// - BubbleCount   out  CNT_W    number of load-use bubbles inserted, saturating
// BEHAVIOUR
// - Reset (async, rst_n = 0): every EX_* output and BubbleCount are 0. An all-zero
//   control set is the canonical bubble.
// - LoadUse (combinational) = ID_Valid & EX_Valid & EX_MemRead & (EX_RdAddr != 0) &
//   ((ID_UseRs1 & EX_RdAddr == ID_RegAddr1) | (ID_UseRs2 & EX_RdAddr == ID_RegAddr2)).
// - Stall_out = Stall_in | (LoadUse & ~Flush).
// - Register update priority at each rising edge:
//   1. Stall_in: hold all EX_* registers. Flush and LoadUse are ignored. Sources keep
//      Flush asserted while stalled.
//   2. Flush: load a bubble (EX_Valid = 0, all controls = 0).
//   3. LoadUse: load a bubble. BubbleCount increments and saturates at all-ones.
//      ID is held by Stall_out. Exactly one bubble per load, because after the bubble
//      EX_MemRead = 0.
//   4. Otherwise: capture all ID_* fields. EX_Valid = ID_Valid.
// - Controls in a bubble: EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch and
//   EX_MemToReg are 0. Data and address fields in a bubble are don't-care but are
//   driven to 0.
// - WB bypass on capture: if WB_RegWrite & WB_RdAddr != 0 & WB_RdAddr == ID_RegAddr1,
//   EX_Rs1Data takes WB_Data instead of ID_Rs1Data. Same rule for rs2. This covers
//   register-file read-before-write in the same cycle.
// - Register x0 never matches any hazard or bypass compare.
// - Latency: one cycle from ID to EX. There are no combinational paths from ID_*
//   data to EX_*.
// - Reset asserted mid-operation clears the pipeline register immediately. The first
//   edge after release captures normally.
// STRUCTURE
// - Shared package (extend parameter_define): ALU op localparams, forwarding-select
//   codes, and a typedef struct packed ex_ctrl_t holding
//   {RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, ALUOp} plus the constant
//   EX_CTRL_BUBBLE = '0.
// - One sub-module: load_use_detect. It is purely combinational and produces LoadUse.
//   The registers, bypass muxes and counter stay in the top module.
// TESTING
// - lw x5 in EX, ID = add x6,x5,x7 (UseRs1) -> LoadUse = 1, Stall_out = 1, next EX is
//   a bubble, BubbleCount = 1, then the add is captured.
// - Load with rd = x0 in EX, ID reads x0 -> LoadUse = 0, no bubble.
// - ID_Rs1Data = 0x11, WB writes x3 = 0xDEADBEEF, ID_RegAddr1 = 3 ->
//   EX_Rs1Data = 0xDEADBEEF.
// - Flush and LoadUse in the same cycle -> bubble, Stall_out = 0, BubbleCount unchanged.
// - Stall_in = 1 for 3 cycles with Flush = 1 -> EX_* held, then a bubble on the first
//   unstalled edge.
// - Drop rst_n mid-stream -> all EX_* and BubbleCount read 0 without waiting for a
//   clock edge.

Source files
------------

// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: widths, ALU op codes,
// forwarding-select codes and the EX control bundle.
package id_ex_hazard_reg_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 16;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

    // x0 is hard-wired to zero, so it never takes part in a dependency.
    function automatic logic addr_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID-stage inputs, WB bypass inputs and registered EX-stage outputs of the
// ID/EX pipeline register.
interface id_ex_hazard_reg_if;
    import id_ex_hazard_reg_pkg::*;

    logic                ID_Valid;
    logic [XLEN-1:0]     ID_PC;
    logic [XLEN-1:0]     ID_Rs1Data;
    logic [XLEN-1:0]     ID_Rs2Data;
    logic [XLEN-1:0]     ID_Imm;
    logic [4:0]          ID_RegAddr1;
    logic [4:0]          ID_RegAddr2;
    logic [4:0]          ID_RdAddr;
    logic                ID_UseRs1;
    logic                ID_UseRs2;
    logic [ALUOP_W-1:0]  ID_ALUOp;
    logic                ID_ALUSrc;
    logic                ID_MemRead;
    logic                ID_MemWrite;
    logic                ID_RegWrite;
    logic                ID_MemToReg;
    logic                ID_Branch;
    logic                WB_RegWrite;
    logic [4:0]          WB_RdAddr;
    logic [XLEN-1:0]     WB_Data;
    logic                Stall_in;
    logic                Flush;

    logic                EX_Valid;
    logic [XLEN-1:0]     EX_PC;
    logic [XLEN-1:0]     EX_Rs1Data;
    logic [XLEN-1:0]     EX_Rs2Data;
    logic [XLEN-1:0]     EX_Imm;
    logic [4:0]          EX_RegAddr1;
    logic [4:0]          EX_RegAddr2;
    logic [4:0]          EX_RdAddr;
    logic                EX_UseRs1;
    logic                EX_UseRs2;
    logic [ALUOP_W-1:0]  EX_ALUOp;
    logic                EX_ALUSrc;
    logic                EX_MemRead;
    logic                EX_MemWrite;
    logic                EX_RegWrite;
    logic                EX_MemToReg;
    logic                EX_Branch;
    logic                Stall_out;
    logic                LoadUse;
    logic [CNT_W-1:0]    BubbleCount;

    modport master (
        output ID_Valid, ID_PC, ID_Rs1Data, ID_Rs2Data, ID_Imm, ID_RegAddr1, ID_RegAddr2,
               ID_RdAddr, ID_UseRs1, ID_UseRs2, ID_ALUOp, ID_ALUSrc, ID_MemRead,
               ID_MemWrite, ID_RegWrite, ID_MemToReg, ID_Branch,
               WB_RegWrite, WB_RdAddr, WB_Data, Stall_in, Flush,
        input  EX_Valid, EX_PC, EX_Rs1Data, EX_Rs2Data, EX_Imm, EX_RegAddr1, EX_RegAddr2,
               EX_RdAddr, EX_UseRs1, EX_UseRs2, EX_ALUOp, EX_ALUSrc, EX_MemRead,
               EX_MemWrite, EX_RegWrite, EX_MemToReg, EX_Branch,
               Stall_out, LoadUse, BubbleCount
    );

    modport slave (
        input  ID_Valid, ID_PC, ID_Rs1Data, ID_Rs2Data, ID_Imm, ID_RegAddr1, ID_RegAddr2,
               ID_RdAddr, ID_UseRs1, ID_UseRs2, ID_ALUOp, ID_ALUSrc, ID_MemRead,
               ID_MemWrite, ID_RegWrite, ID_MemToReg, ID_Branch,
               WB_RegWrite, WB_RdAddr, WB_Data, Stall_in, Flush,
        output EX_Valid, EX_PC, EX_Rs1Data, EX_Rs2Data, EX_Imm, EX_RegAddr1, EX_RegAddr2,
               EX_RdAddr, EX_UseRs1, EX_UseRs2, EX_ALUOp, EX_ALUSrc, EX_MemRead,
               EX_MemWrite, EX_RegWrite, EX_MemToReg, EX_Branch,
               Stall_out, LoadUse, BubbleCount
    );

endinterface

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Combinational load-use hazard detect: a valid load in EX whose rd is read
// by the valid instruction sitting in ID.
module load_use_detect
    import id_ex_hazard_reg_pkg::*;
(
    input  logic       id_valid_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] id_reg_addr1_i,
    input  logic [4:0] id_reg_addr2_i,
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    output logic       load_use_o
);

    logic rs1_dep;
    logic rs2_dep;

    assign rs1_dep    = id_use_rs1_i & addr_match(ex_rd_addr_i, id_reg_addr1_i);
    assign rs2_dep    = id_use_rs2_i & addr_match(ex_rd_addr_i, id_reg_addr2_i);
    assign load_use_o = id_valid_i & ex_valid_i & ex_mem_read_i & (rs1_dep | rs2_dep);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// stall hold and a WB->ID register-file bypass on capture.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_hazard_reg_if.slave bus
);

    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      rs1_q, rs1_d;
    logic [XLEN-1:0]      rs2_q, rs2_d;
    logic [XLEN-1:0]      imm_q, imm_d;
    logic [4:0]           ra1_q, ra1_d;
    logic [4:0]           ra2_q, ra2_d;
    logic [4:0]           rd_q, rd_d;
    logic                 use1_q, use1_d;
    logic                 use2_q, use2_d;
    ex_ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 load_use;
    ex_ctrl_t             id_ctrl;
    logic [XLEN-1:0]      rs1_byp;
    logic [XLEN-1:0]      rs2_byp;

    load_use_detect u_load_use_detect (
        .id_valid_i     (bus.ID_Valid),
        .id_use_rs1_i   (bus.ID_UseRs1),
        .id_use_rs2_i   (bus.ID_UseRs2),
        .id_reg_addr1_i (bus.ID_RegAddr1),
        .id_reg_addr2_i (bus.ID_RegAddr2),
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_rd_addr_i   (rd_q),
        .load_use_o     (load_use)
    );

    assign id_ctrl = '{reg_write:  bus.ID_RegWrite,
                       mem_read:   bus.ID_MemRead,
                       mem_write:  bus.ID_MemWrite,
                       mem_to_reg: bus.ID_MemToReg,
                       branch:     bus.ID_Branch,
                       alu_src:    bus.ID_ALUSrc,
                       alu_op:     bus.ID_ALUOp};

    // The register file reads before it writes, so a same-cycle WB result is taken here.
    assign rs1_byp = (bus.WB_RegWrite && addr_match(bus.WB_RdAddr, bus.ID_RegAddr1))
                     ? bus.WB_Data : bus.ID_Rs1Data;
    assign rs2_byp = (bus.WB_RegWrite && addr_match(bus.WB_RdAddr, bus.ID_RegAddr2))
                     ? bus.WB_Data : bus.ID_Rs2Data;

    assign bus.LoadUse   = load_use;
    assign bus.Stall_out = bus.Stall_in | (load_use & ~bus.Flush);

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        ra1_d   = ra1_q;
        ra2_d   = ra2_q;
        rd_d    = rd_q;
        use1_d  = use1_q;
        use2_d  = use2_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (!bus.Stall_in) begin
            if (bus.Flush || load_use) begin
                valid_d = 1'b0;
                pc_d    = '0;
                rs1_d   = '0;
                rs2_d   = '0;
                imm_d   = '0;
                ra1_d   = '0;
                ra2_d   = '0;
                rd_d    = '0;
                use1_d  = 1'b0;
                use2_d  = 1'b0;
                ctrl_d  = EX_CTRL_BUBBLE;
                // Only hazard bubbles are counted; a flush bubble is not a stall.
                if (!bus.Flush && (cnt_q != {CNT_W{1'b1}}))
                    cnt_d = cnt_q + 1'b1;
            end else begin
                valid_d = bus.ID_Valid;
                pc_d    = bus.ID_PC;
                rs1_d   = rs1_byp;
                rs2_d   = rs2_byp;
                imm_d   = bus.ID_Imm;
                ra1_d   = bus.ID_RegAddr1;
                ra2_d   = bus.ID_RegAddr2;
                rd_d    = bus.ID_RdAddr;
                use1_d  = bus.ID_UseRs1;
                use2_d  = bus.ID_UseRs2;
                ctrl_d  = id_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            rd_q    <= '0;
            use1_q  <= 1'b0;
            use2_q  <= 1'b0;
            ctrl_q  <= EX_CTRL_BUBBLE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            rd_q    <= rd_d;
            use1_q  <= use1_d;
            use2_q  <= use2_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.EX_Valid    = valid_q;
    assign bus.EX_PC       = pc_q;
    assign bus.EX_Rs1Data  = rs1_q;
    assign bus.EX_Rs2Data  = rs2_q;
    assign bus.EX_Imm      = imm_q;
    assign bus.EX_RegAddr1 = ra1_q;
    assign bus.EX_RegAddr2 = ra2_q;
    assign bus.EX_RdAddr   = rd_q;
    assign bus.EX_UseRs1   = use1_q;
    assign bus.EX_UseRs2   = use2_q;
    assign bus.EX_ALUOp    = ctrl_q.alu_op;
    assign bus.EX_ALUSrc   = ctrl_q.alu_src;
    assign bus.EX_MemRead  = ctrl_q.mem_read;
    assign bus.EX_MemWrite = ctrl_q.mem_write;
    assign bus.EX_RegWrite = ctrl_q.reg_write;
    assign bus.EX_MemToReg = ctrl_q.mem_to_reg;
    assign bus.EX_Branch   = ctrl_q.branch;
    assign bus.BubbleCount = cnt_q;

endmodule
